kernel_coef_reader: RTL and testbench

Read-side sequencer for the 5x5 convolution-kernel coefficient ROM. On a `start` pulse it sweeps ROM addresses 0..KSIZE*KSIZE-1 through the ROM's one-cycle registered read port. It buffers the returned words in a small FIFO and presents each coefficient to the downstream convolution datapath on a valid/ready stream, with index and last flag. It sits between the coefficient ROM and the filter MAC array in the D8M loopback pipeline.

---
 rtl/kernel_coef_reader.sv | 239 +++++++++++++++++++++++
 tb/tb_kernel_coef_reader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_coef_reader.sv
// kernel_coef_reader: sweeps the coefficient ROM (addresses 0..N-1) and streams each coefficient with index/last.
// Latency: 2 cycles from accepted start to first coef_valid; one beat per cycle while coef_ready stays high.
// Backpressure: reads stop once FIFO count + in-flight read reaches 3; coef_ready never reaches rom_rd_en combinationally.
// Optional feature: define KCR_SUM_EN to build the running coefficient sum on coef_sum (tied to 0 otherwise).

// Small generic synchronous FIFO with flush; the writer is responsible for never overflowing it.
module kcr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          rd_fire;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_vld  = (count != '0);
    assign rd_dat  = mem[rptr];
    assign rd_fire = rd_vld & rd_rdy;

    // Pointer and occupancy bookkeeping; flush empties the queue without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_vld) begin
                wptr <= ptr_next(wptr);
            end
            if (rd_fire) begin
                rptr <= ptr_next(rptr);
            end
            case ({wr_vld, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero before the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_vld && !flush) begin
            mem[wptr] <= wr_dat;
        end
    end
endmodule

module kernel_coef_reader #(
    parameter int KSIZE  = 5,
    parameter int ADDR_W = 5,
    parameter int ROM_W  = 5120,
    parameter int COEF_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     rom_rd_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [ROM_W-1:0]         rom_data,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic [COEF_W-1:0]        coef_data,
    output logic [ADDR_W-1:0]        coef_index,
    output logic                     coef_last,
    output logic [COEF_W+ADDR_W-1:0] coef_sum
);
    localparam int                N         = KSIZE * KSIZE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam int                SUM_W     = COEF_W + ADDR_W;
    localparam int                ENT_W     = ADDR_W + COEF_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] issue_addr;
    logic              infl;
    logic [ADDR_W-1:0] infl_idx;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;
    logic              issue;
    logic              start_acc;
    logic              pop;
    logic              last_pop;
    logic [ENT_W-1:0]  push_dat;
    logic [ENT_W-1:0]  head_dat;
    logic              unused_rom_hi;

    // Only the low COEF_W bits of the ROM word carry the coefficient.
    assign unused_rom_hi = ^rom_data[ROM_W-1:COEF_W];

    // Occupancy counts buffered words plus the read on its way back; both are registered,
    // so the issue decision never sees coef_ready in the same cycle.
    assign occ       = {1'b0, fifo_count} + {2'b00, infl};
    assign issue     = (state == S_RUN) && (occ < 3'd3);
    assign rom_rd_en = issue;
    assign rom_addr  = issue_addr;

    assign start_acc = (state == S_IDLE) && start && !abort;
    assign pop       = coef_valid & coef_ready;
    assign last_pop  = pop & coef_last;
    assign busy      = (state != S_IDLE);

    assign push_dat   = {infl_idx, rom_data[COEF_W-1:0]};
    assign coef_data  = head_dat[COEF_W-1:0];
    assign coef_index = head_dat[ENT_W-1:COEF_W];
    assign coef_last  = coef_valid & (coef_index == LAST_ADDR);

    // Sweep control: abort wins over everything; done pulses on the edge after the final beat is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (issue && (issue_addr == LAST_ADDR)) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        // The last index is always the final word, so once it leaves with
                        // nothing else buffered or in flight the sweep is complete.
                        if (last_pop && (fifo_count == 2'd1) && !infl) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Issue counter doubles as the ROM address; parked at zero whenever idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_addr <= '0;
        end else if (abort || (state == S_IDLE)) begin
            issue_addr <= '0;
        end else if (issue) begin
            issue_addr <= issue_addr + 1'b1;
        end
    end

    // Track the single outstanding ROM read and the kernel index it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            infl     <= 1'b0;
            infl_idx <= '0;
        end else if (abort) begin
            infl     <= 1'b0;
            infl_idx <= '0;
        end else begin
            infl <= issue;
            if (issue) begin
                infl_idx <= issue_addr;
            end
        end
    end

    // Returned words land here the cycle after capture; abort flushes, so late words are dropped.
    kcr_fifo #(
        .W     (ENT_W),
        .DEPTH (3),
        .CW    (2)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (abort),
        .wr_vld (infl),
        .wr_dat (push_dat),
        .rd_rdy (coef_ready),
        .rd_vld (coef_valid),
        .rd_dat (head_dat),
        .count  (fifo_count)
    );

`ifdef KCR_SUM_EN
    logic [SUM_W-1:0] sum_q;

    // Running sum of accepted coefficients; kept after done, cleared by a new start or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (abort || start_acc) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + SUM_W'(coef_data);
        end
    end

    assign coef_sum = sum_q;
`else
    logic unused_sum_inputs;

    assign unused_sum_inputs = start_acc;
    assign coef_sum          = '0;
`endif
endmodule

// File: tb/tb_kernel_coef_reader.sv
module tb_kernel_coef_reader;
    localparam int KSIZE  = 5;
    localparam int ADDR_W = 5;
    localparam int ROM_W  = 5120;
    localparam int COEF_W = 24;
    localparam int N      = KSIZE * KSIZE;
`ifdef KCR_SUM_EN
    localparam bit SUM_ON = 1'b1;
`else
    localparam bit SUM_ON = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic                     abort;
    logic                     busy;
    logic                     done;
    logic                     rom_rd_en;
    logic [ADDR_W-1:0]        rom_addr;
    logic [ROM_W-1:0]         rom_data;
    logic                     coef_valid;
    logic                     coef_ready;
    logic [COEF_W-1:0]        coef_data;
    logic [ADDR_W-1:0]        coef_index;
    logic                     coef_last;
    logic [COEF_W+ADDR_W-1:0] coef_sum;

    kernel_coef_reader #(
        .KSIZE  (KSIZE),
        .ADDR_W (ADDR_W),
        .ROM_W  (ROM_W),
        .COEF_W (COEF_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .rom_rd_en  (rom_rd_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .coef_index (coef_index),
        .coef_last  (coef_last),
        .coef_sum   (coef_sum)
    );

    always #5 clk = ~clk;

    // ROM with one-cycle registered read; upper bits filled with ones to expose bad slicing.
    logic [COEF_W-1:0] rom_mem [32];
    always @(posedge clk) begin
        if (rom_rd_en) begin
            rom_data <= {{(ROM_W - COEF_W){1'b1}}, rom_mem[rom_addr]};
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state: what the stream should look like, from the sweep rules.
    bit                exp_busy;
    bit                exp_done;
    int                exp_idx;
    longint            exp_sum;
    int                n_hs;
    bit                stall_prev;
    logic [COEF_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_idx;
    bit                chk_nobubble;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_busy     = 1'b0;
        exp_done     = 1'b0;
        exp_idx      = 0;
        exp_sum      = 0;
        n_hs         = 0;
        stall_prev   = 1'b0;
        chk_nobubble = 1'b0;
    endtask

    task automatic load_kernel();
        int k1d [5] = '{1, 3, 4, 3, 1};
        int k2d [5] = '{1, 3, 4, 3, 1};
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                rom_mem[r*5 + c] = COEF_W'(k1d[r] * k2d[c]);
            end
        end
        // Centre tap differs from the outer product pattern.
        rom_mem[6]  = 24'hC;  rom_mem[7]  = 24'h13; rom_mem[8]  = 24'hC;
        rom_mem[11] = 24'h13; rom_mem[12] = 24'h20; rom_mem[13] = 24'h13;
        rom_mem[16] = 24'hC;  rom_mem[17] = 24'h13; rom_mem[18] = 24'hC;
        for (int i = N; i < 32; i++) rom_mem[i] = '0;
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++) rom_mem[i] = COEF_W'($urandom);
    endtask

    // Called at a falling edge: check current outputs against the model, drive inputs
    // for the next rising edge, advance the model, then move to the next falling edge.
    task automatic cyc(input logic rdy, input logic st, input logic ab);
        bit hs;
        bit was_busy;
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("sum", coef_sum, SUM_ON ? 64'(exp_sum) : 64'd0);
        if (!exp_busy) begin
            check("idle_valid", coef_valid, 1'b0);
            check("idle_rd_en", rom_rd_en, 1'b0);
        end
        if (stall_prev) begin
            check("hold_valid", coef_valid, 1'b1);
            check("hold_data", coef_data, prev_data);
            check("hold_index", coef_index, prev_idx);
        end
        if (chk_nobubble && exp_busy && n_hs < N) check("no_bubble", coef_valid, 1'b1);

        coef_ready = rdy;
        start      = st;
        abort      = ab;

        was_busy = exp_busy;
        exp_done = 1'b0;
        hs = coef_valid && rdy;
        if (hs) begin
            if (exp_idx < N) begin
                check("index", coef_index, exp_idx);
                check("data", coef_data, rom_mem[exp_idx]);
                check("last", coef_last, exp_idx == N - 1);
                exp_sum += rom_mem[exp_idx];
                if (exp_idx == N - 1 && !ab) begin
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                end
            end else begin
                check("extra_beat", coef_valid, 1'b0);
            end
            exp_idx++;
            n_hs++;
        end
        if (ab) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_idx  = 0;
            exp_sum  = 0;
        end else if (st && !was_busy) begin
            exp_busy = 1'b1;
            exp_idx  = 0;
            exp_sum  = 0;
            n_hs     = 0;
        end
        stall_prev = coef_valid && !rdy && !ab;
        prev_data  = coef_data;
        prev_idx   = coef_index;
        @(negedge clk);
    endtask

    task automatic run_to_done(input string tag, input bit rnd);
        for (int k = 0; k < 400; k++) begin
            if (done) break;
            cyc(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_beats"}, n_hs, N);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        coef_ready = 1'b0;
        model_reset();
        load_kernel();

        // Reset state
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", rom_rd_en, 1'b0);
        check("rst_valid", coef_valid, 1'b0);
        check("rst_last", coef_last, 1'b0);
        check("rst_addr", rom_addr, 0);
        check("rst_index", coef_index, 0);
        check("rst_data", coef_data, 0);
        check("rst_sum", coef_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full sweep with ready held high: latency, throughput, done timing, sum
        cyc(1'b1, 1'b1, 1'b0);
        for (int j = 0; j <= 28; j++) begin
            if (j == 0) begin
                check("t1_valid_e0", coef_valid, 1'b0);
                check("t1_rd_en_e0", rom_rd_en, 1'b1);
                check("t1_addr_e0", rom_addr, 0);
            end
            if (j == 1) check("t1_valid_e1", coef_valid, 1'b0);
            if (j == 2) begin
                check("t1_valid_e2", coef_valid, 1'b1);
                check("t1_index_e2", coef_index, 0);
                check("t1_data_e2", coef_data, 1);
                chk_nobubble = 1'b1;
            end
            if (j == 27) begin
                check("t1_done_e27", done, 1'b1);
                check("t1_beats", n_hs, N);
            end
            if (j == 28) begin
                check("t1_done_e28", done, 1'b0);
                check("t1_sum", coef_sum, SUM_ON ? 200 : 0);
            end
            cyc(1'b1, 1'b0, 1'b0);
        end
        chk_nobubble = 1'b0;

        // Backpressure: ready low for 10 cycles after first valid
        cyc(1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 12; j++) begin
            if (j == 5 || j == 11) begin
                check("t2_rd_en_stall", rom_rd_en, 1'b0);
                check("t2_addr_stall", rom_addr, 3);
                check("t2_data_stall", coef_data, 1);
                check("t2_index_stall", coef_index, 0);
            end
            cyc(1'b0, 1'b0, 1'b0);
        end
        chk_nobubble = 1'b1;
        run_to_done("t2", 1'b0);
        chk_nobubble = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);

        // Random ready over a random-content ROM
        load_random();
        cyc(1'b1, 1'b1, 1'b0);
        run_to_done("t3", 1'b1);
        cyc(1'b1, 1'b0, 1'b0);

        // Abort in the cycle index 7 is accepted, then a clean restart
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (coef_valid && coef_index == 7) break;
            cyc(1'b1, 1'b0, 1'b0);
        end
        check("t4_at_idx7", coef_index, 7);
        cyc(1'b1, 1'b0, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_valid", coef_valid, 1'b0);
        check("t4_done", done, 1'b0);
        check("t4_sum", coef_sum, 0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        run_to_done("t4", 1'b1);
        cyc(1'b1, 1'b0, 1'b0);

        // start while busy is ignored
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (coef_valid && coef_index == 10) break;
            cyc(1'b1, 1'b0, 1'b0);
        end
        check("t5_at_idx10", coef_index, 10);
        cyc(1'b1, 1'b1, 1'b0);
        run_to_done("t5", 1'b0);
        cyc(1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-sweep
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", busy, 1'b0);
        check("ar_done", done, 1'b0);
        check("ar_rd_en", rom_rd_en, 1'b0);
        check("ar_valid", coef_valid, 1'b0);
        check("ar_last", coef_last, 1'b0);
        check("ar_addr", rom_addr, 0);
        check("ar_index", coef_index, 0);
        check("ar_data", coef_data, 0);
        check("ar_sum", coef_sum, 0);
        start = 1'b0;
        abort = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // start and abort together in IDLE
        cyc(1'b1, 1'b1, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_rd_en", rom_rd_en, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("t6_rd_en2", rom_rd_en, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
